picorv32_ram_bridge: RTL and testbench
======================================

Name: picorv32_ram_bridge

Overview:
- Converts the picorv32 native memory bus (valid/ready/addr/wdata/wstrb/rdata) into port A signals for one dual-port 2048x32 block-RAM bank: 16-bit byte address, byte write enables, select and write data.
- Sits directly between the CPU bus interconnect and the RAM port A.
- Decodes a 64 KB window and sequences the RAM's one-cycle synchronous read latency with a small FSM. It also registers read data and produces a single-cycle mem_ready pulse.
- Non-matching addresses are ignored so the top level can mux several bridges and peripherals.

Parameters:
- BASE_ADDR, 16'h0000: value compared against mem_addr[31:16] for window hit.
- READ_PIPE, 0: 0 or 1. When 1, adds one extra register stage on the read data path for timing; reads take one more cycle.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  CPU request valid; held until mem_ready.
- mem_addr  in  32  CPU byte address.
- mem_wdata  in  32  CPU write data.
- mem_wstrb  in  4  byte strobes; 4'b0000 means read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data; valid while mem_ready=1.
- hit  out  1  combinational; mem_valid & (mem_addr[31:16]==BASE_ADDR).
- ram_ada  out  16  RAM port A byte address = mem_addr[15:0]; bits [15:13] select the bank.
- ram_dia  out  32  RAM write data = mem_wdata.
- ram_wrea  out  4  RAM byte write enables.
- ram_sela  out  1  RAM port A select (access strobe).
- ram_doa  in  32  RAM port A read data, valid one cycle after a select.

Behaviour:
- FSM states: IDLE, RD_WAIT, RD_PIPE (exists only when READ_PIPE=1), RESP.
- Reset values: state=IDLE, mem_ready=0, mem_rdata=32'h0, ram_wrea=0, ram_sela=0.
- ram_ada and ram_dia are pass-through combinational copies of mem_addr[15:0] and mem_wdata at all times.
- ram_sela = (state==IDLE) & hit & ~reset.
- ram_wrea = mem_wstrb when ram_sela=1, else 4'b0000. Write enables are therefore active for exactly one cycle per write.
- mem_addr[1:0] are passed through unchanged; the RAM ignores them. No misalignment checking.
- IDLE + hit + wstrb!=0 (write), issued in cycle T:
  - RAM written at edge T.
  - Go to RESP; mem_ready=1 in cycle T+1.
- IDLE + hit + wstrb==0 (read), issued in cycle T:
  - Go to RD_WAIT. ram_doa is valid in cycle T+1.
  - READ_PIPE=0: RD_WAIT captures ram_doa into mem_rdata at edge T+1, then RESP; mem_ready=1 in cycle T+2.
  - READ_PIPE=1: RD_WAIT captures ram_doa into an internal register, RD_PIPE copies it to mem_rdata, then RESP; mem_ready=1 in cycle T+3.
- RESP:
  - mem_ready=1 for exactly one cycle, then unconditional return to IDLE.
  - No new request is accepted during RESP. Back-to-back throughput: writes 2 cycles, reads 3 cycles (4 with READ_PIPE=1).
- mem_ready is a registered output: asserted on entering RESP, cleared on leaving it.
- mem_rdata holds its last captured value outside reads and is not cleared after a write. Only its value during mem_ready after a read is meaningful.
- Miss (mem_valid=1, hit=0):
  - No RAM activity; FSM stays in IDLE; mem_ready stays 0 indefinitely.
  - Another slave is responsible for the response.
- mem_valid dropping mid-transaction (in RD_WAIT, RD_PIPE or RESP) is ignored: the sequence completes and mem_ready still pulses. No write is repeated.
- mem_addr or mem_wstrb changing after the issue cycle does not affect the in-flight transaction.
- Reset asserted in any state:
  - ram_sela and ram_wrea are forced to 0 in the same cycle, so no write occurs during reset.
  - Next cycle: state=IDLE, mem_ready=0, mem_rdata=0.
  - A read in flight is discarded without a mem_ready pulse.
- The bridge never drives RAM port B.

Test Plan:
- Word write then read, READ_PIPE=0, BASE_ADDR=0:
  - write 0x0000_0104 = 32'hDEADBEEF, wstrb=4'hF -> ram_wrea=4'hF for 1 cycle; mem_ready at T+1.
  - read 0x0000_0104 -> ram_sela 1 cycle; mem_ready at T+2 with mem_rdata=32'hDEADBEEF.
- Byte write: over 32'hDEADBEEF, write 32'h0000_5A00 with wstrb=4'b0010 to the same address -> ram_wrea=4'b0010; readback = 32'hDEAD5AEF.
- Miss: BASE_ADDR=16'h0001, mem_addr=32'h0000_0010, valid held 10 cycles -> hit=0, ram_sela=0, ram_wrea=0, mem_ready=0 throughout.
- READ_PIPE=1: read of a preloaded word 32'h12345678 -> mem_ready exactly at T+3 with mem_rdata=32'h12345678. Back-to-back reads are spaced 4 cycles.
- Reset mid-read: assert reset in RD_WAIT for 1 cycle -> no mem_ready pulse; state IDLE; mem_rdata=0. The next read completes normally at T+2.
- Reset during write issue: reset=1 coincident with a hit write -> ram_wrea=0 that cycle; the old RAM content is unchanged on readback.

Source files
------------

// File: rtl/picorv32_ram_bridge.sv
// picorv32_ram_bridge
//
// Bridges the picorv32 native memory bus onto port A of one 2048x32
// block-RAM bank. A request is claimed only when mem_addr[31:16] matches
// BASE_ADDR, so several bridges and peripherals can share the CPU bus. All
// other requests are ignored. The RAM has one cycle of synchronous read
// latency. A small FSM waits that cycle, and optionally one more register
// cycle, before it returns a single-cycle mem_ready pulse.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   mem_valid         CPU request valid (held until mem_ready)
//   mem_addr          CPU byte address
//   mem_wdata         CPU write data
//   mem_wstrb         byte strobes, 4'b0000 = read
//   mem_ready         registered one-cycle completion pulse
//   mem_rdata         registered read data, valid while mem_ready=1
//   hit               combinational window hit
//   ram_ada           RAM port A byte address (mem_addr[15:0])
//   ram_dia           RAM port A write data (mem_wdata)
//   ram_wrea          RAM port A byte write enables
//   ram_sela          RAM port A select
//   ram_doa           RAM port A read data, valid one cycle after select
module picorv32_ram_bridge #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          READ_PIPE = 32'sd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        hit,
    output logic [15:0] ram_ada,
    output logic [31:0] ram_dia,
    output logic [3:0]  ram_wrea,
    output logic        ram_sela,
    input  logic [31:0] ram_doa
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_PIPE = 2'd2,   // only reachable when the extra read stage is enabled
        RESP    = 2'd3
    } state_t;

    localparam logic PIPE_EN = (READ_PIPE != 32'sd0);

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pipe_r;

    // Window decode and RAM port A strobes. Reset gates the select so no write can slip through
    always_comb begin
        hit      = mem_valid & (mem_addr[31:16] == BASE_ADDR);
        ram_ada  = mem_addr[15:0];
        ram_dia  = mem_wdata;
        ram_sela = (state_r == IDLE) & hit & ~reset;
        if (ram_sela) begin
            ram_wrea = mem_wstrb;
        end else begin
            ram_wrea = 4'b0000;
        end
    end

    // Next-state logic: writes go straight to RESP, reads wait out the RAM latency
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (ram_sela) begin
                    if (mem_wstrb != 4'b0000) begin
                        state_s = RESP;
                    end else begin
                        state_s = RD_WAIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD_WAIT: begin
                if (PIPE_EN) begin
                    state_s = RD_PIPE;
                end else begin
                    state_s = RESP;
                end
            end
            RD_PIPE: state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register, read-data capture and registered completion pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0000_0000;
            pipe_r    <= 32'h0000_0000;
        end else begin
            state_r   <= state_s;
            mem_ready <= (state_s == RESP);
            // ram_doa is valid during RD_WAIT; capture directly or into the pipe stage
            if (state_r == RD_WAIT) begin
                if (PIPE_EN) begin
                    pipe_r <= ram_doa;
                end else begin
                    mem_rdata <= ram_doa;
                end
            end
            if (state_r == RD_PIPE) begin
                mem_rdata <= pipe_r;
            end
        end
    end

endmodule

// File: tb/tb_picorv32_ram_bridge.sv
// Testbench for picorv32_ram_bridge.
// dut0: BASE_ADDR=16'h0000, READ_PIPE=0. dut1: BASE_ADDR=16'h0001, READ_PIPE=1.
// Each bridge drives its own behavioural RAM bank. The bench keeps a shadow
// memory model. Expected read data is pushed to a scoreboard queue when a
// read is issued, then popped and compared when mem_ready arrives.
module tb_picorv32_ram_bridge;

    logic clk = 1'b0;
    logic reset;

    logic        valid0, valid1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  wstrb0, wstrb1;
    logic        ready0, ready1, hit0, hit1, sela0, sela1;
    logic [31:0] rdata0, rdata1, dia0, dia1, doa0, doa1;
    logic [15:0] ada0, ada1;
    logic [3:0]  wrea0, wrea1;

    logic [31:0] ram0 [2048];
    logic [31:0] ram1 [2048];
    logic [31:0] model [2][2048];
    logic [31:0] sb [$];

    int n_assert = 0;
    int n_fail   = 0;

    picorv32_ram_bridge #(.BASE_ADDR(16'h0000), .READ_PIPE(0)) dut0 (
        .clk(clk), .reset(reset), .mem_valid(valid0), .mem_addr(addr0),
        .mem_wdata(wdata0), .mem_wstrb(wstrb0), .mem_ready(ready0),
        .mem_rdata(rdata0), .hit(hit0), .ram_ada(ada0), .ram_dia(dia0),
        .ram_wrea(wrea0), .ram_sela(sela0), .ram_doa(doa0)
    );

    picorv32_ram_bridge #(.BASE_ADDR(16'h0001), .READ_PIPE(1)) dut1 (
        .clk(clk), .reset(reset), .mem_valid(valid1), .mem_addr(addr1),
        .mem_wdata(wdata1), .mem_wstrb(wstrb1), .mem_ready(ready1),
        .mem_rdata(rdata1), .hit(hit1), .ram_ada(ada1), .ram_dia(dia1),
        .ram_wrea(wrea1), .ram_sela(sela1), .ram_doa(doa1)
    );

    // Clock generation
    always #5 clk = ~clk;

    // RAM bank behind dut0: byte-enabled write, one-cycle synchronous read
    always @(posedge clk) begin
        if (sela0) begin
            for (int i = 0; i < 4; i++) begin
                if (wrea0[i]) ram0[ada0[12:2]][8*i +: 8] <= dia0[8*i +: 8];
            end
            doa0 <= ram0[ada0[12:2]];
        end
    end

    // RAM bank behind dut1
    always @(posedge clk) begin
        if (sela1) begin
            for (int i = 0; i < 4; i++) begin
                if (wrea1[i]) ram1[ada1[12:2]][8*i +: 8] <= dia1[8*i +: 8];
            end
            doa1 <= ram1[ada1[12:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_bus(input bit w, input logic v, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        if (w) begin
            valid1 = v; addr1 = a; wdata1 = d; wstrb1 = s;
        end else begin
            valid0 = v; addr0 = a; wdata0 = d; wstrb0 = s;
        end
    endtask

    // One transaction, started and finished at posedge+1. lat is the expected
    // number of cycles from issue to mem_ready. hold keeps mem_valid asserted so
    // the next call issues in the cycle right after the response.
    task automatic xact(input bit w, input string tag, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input int lat, input bit hold);
        int n;
        int idx;
        logic [31:0] e;
        idx = int'(a[12:2]);
        set_bus(w, 1'b1, a, d, s);
        if (s == 4'h0) begin
            sb.push_back(model[w][idx]);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) model[w][idx][8*i +: 8] = d[8*i +: 8];
            end
        end
        @(negedge clk);
        chk({tag, ".hit"},  w ? hit1  : hit0,  32'd1);
        chk({tag, ".sela"}, w ? sela1 : sela0, 32'd1);
        chk({tag, ".wrea"}, w ? wrea1 : wrea0, {28'd0, s});
        chk({tag, ".ada"},  w ? ada1  : ada0,  {16'd0, a[15:0]});
        chk({tag, ".dia"},  w ? dia1  : dia0,  d);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            chk({tag, ".busy_sela"}, w ? sela1 : sela0, 32'd0);
        end while (((w ? ready1 : ready0) !== 1'b1) && (n < 20));
        chk({tag, ".latency"}, n, lat);
        if (s == 4'h0) begin
            e = sb.pop_front();
            chk({tag, ".rdata"}, w ? rdata1 : rdata0, e);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            set_bus(w, 1'b0, a, d, 4'h0);
            @(negedge clk);
            chk({tag, ".ready_pulse"}, w ? ready1 : ready0, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    // Directed sequence
    initial begin
        for (int i = 0; i < 2048; i++) begin
            model[0][i] = 32'h0;
            model[1][i] = 32'h0;
        end
        reset = 1'b1;
        set_bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_bus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.ready0", ready0, 32'd0);
        chk("rst.rdata0", rdata0, 32'h0);
        chk("rst.sela0",  sela0,  32'd0);
        chk("rst.wrea0",  wrea0,  32'd0);
        chk("rst.ready1", ready1, 32'd0);
        chk("rst.rdata1", rdata1, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Word write and readback, then byte merge
        xact(1'b0, "wr_word", 32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 1, 1'b0);
        xact(1'b0, "rd_word", 32'h0000_0104, 32'h0, 4'h0, 2, 1'b0);
        xact(1'b0, "wr_byte", 32'h0000_0104, 32'h0000_5A00, 4'b0010, 1, 1'b0);
        xact(1'b0, "rd_byte", 32'h0000_0104, 32'h0, 4'h0, 2, 1'b0);
        // Split strobes over a second word
        xact(1'b0, "wr_w2",   32'h0000_0200, 32'h1122_3344, 4'hF, 1, 1'b0);
        xact(1'b0, "wr_s9",   32'h0000_0200, 32'hA1B2_C3D4, 4'b1001, 1, 1'b0);
        xact(1'b0, "rd_w2",   32'h0000_0200, 32'h0, 4'h0, 2, 1'b0);
        // Write immediately followed by a read (2-cycle write throughput)
        xact(1'b0, "b2b_wr",  32'h0000_0300, 32'h0F0F_A5A5, 4'hF, 1, 1'b1);
        xact(1'b0, "b2b_rd",  32'h0000_0300, 32'h0, 4'h0, 2, 1'b0);

        // Miss on dut1: no RAM activity, no response, for 10 cycles
        set_bus(1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF);
        repeat (10) begin
            @(negedge clk);
            chk("miss.hit",   hit1,   32'd0);
            chk("miss.sela",  sela1,  32'd0);
            chk("miss.wrea",  wrea1,  32'd0);
            chk("miss.ready", ready1, 32'd0);
        end
        @(posedge clk);
        #1;
        set_bus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);

        // READ_PIPE=1: preload two words, then back-to-back reads spaced 4 cycles
        xact(1'b1, "p_wr0", 32'h0001_0040, 32'h1234_5678, 4'hF, 1, 1'b0);
        xact(1'b1, "p_wr1", 32'h0001_0044, 32'hCAFE_F00D, 4'hF, 1, 1'b0);
        xact(1'b1, "p_rd0", 32'h0001_0040, 32'h0, 4'h0, 3, 1'b1);
        xact(1'b1, "p_rd1", 32'h0001_0044, 32'h0, 4'h0, 3, 1'b0);

        // Reset while dut0 sits in RD_WAIT: read discarded, rdata cleared
        set_bus(1'b0, 1'b1, 32'h0000_0104, 32'h0, 4'h0);
        @(negedge clk);
        chk("rrd.issue_sela", sela0, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rrd.sela", sela0, 32'd0);
        chk("rrd.wrea", wrea0, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) begin
            @(negedge clk);
            chk("rrd.ready", ready0, 32'd0);
            chk("rrd.rdata", rdata0, 32'h0);
        end
        @(posedge clk);
        #1;
        xact(1'b0, "rrd.next", 32'h0000_0104, 32'h0, 4'h0, 2, 1'b0);

        // Reset coincident with a hit write: nothing may reach the RAM
        reset = 1'b1;
        set_bus(1'b0, 1'b1, 32'h0000_0104, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        chk("rwr.hit",  hit0,  32'd1);
        chk("rwr.sela", sela0, 32'd0);
        chk("rwr.wrea", wrea0, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("rwr.ready", ready0, 32'd0);
        @(posedge clk);
        #1;
        xact(1'b0, "rwr.readback", 32'h0000_0104, 32'h0, 4'h0, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
